// File: rtl/spi_divider_pkg.sv
// Shared ISA definitions for the mini serial processor and its divider peripheral.
// Holds the operation encoding, the division packet layout and the bus geometry.
package spi_divider_pkg;

  localparam int REGISTER_SIZE    = 16;
  localparam int NSS_WIDTH        = 4;
  localparam int DIV_NSS_POSITION = 3;

  typedef enum logic [2:0] {
    ADD,
    SUB,
    SHIFT_LEFT,
    SHIFT_RIGHT,
    MUL,
    DIV,
    REM
  } Operation;

  // Sent LSB first on the wire, so rem_sel is the first bit after the start bit.
  typedef struct packed {
    logic [REGISTER_SIZE-1:0] divisor;
    logic [REGISTER_SIZE-1:0] dividend;
    logic                     rem_sel;
  } DivPacket;

endpackage

// File: rtl/spi_divider_if.sv
// Shared serial bus between the processor and its downstream peripherals.
// sclk is the system clock; each peripheral owns one active-low nss line.
interface Spi
  import spi_divider_pkg::*;
#(
  parameter int NssWidth = NSS_WIDTH
);
  logic                sclk;
  logic [NssWidth-1:0] nss;
  logic                mosi;
  logic                miso;

  modport Controller (output sclk, output nss, output mosi, input miso);
  modport Peripheral (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_divider_div_core.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// o_done and the results are valid in the cycle of the final step so the caller can latch on that edge.
module div_core
  import spi_divider_pkg::*;
#(
  parameter int Width = REGISTER_SIZE
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [Width-1:0] i_dividend,
  input  logic [Width-1:0] i_divisor,
  output logic [Width-1:0] o_quotient,
  output logic [Width-1:0] o_remainder,
  output logic             o_done
);

  localparam int StepBits = (Width > 1) ? $clog2(Width) : 1;
  typedef logic [StepBits-1:0] step_t;
  localparam step_t LastStep = step_t'(Width - 1);

  logic             busy_q, busy_d;
  logic             zero_q, zero_d;
  step_t            count_q, count_d;
  logic [Width:0]   rem_q, rem_d;
  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] divisor_q, divisor_d;

  logic [Width:0]   shifted;
  logic [Width:0]   trial;
  logic             borrow;
  logic [Width:0]   step_rem;
  logic [Width-1:0] step_quo;
  logic             last_step;

  // The partial remainder never exceeds the divisor, so its top bit only matters inside the trial.
  logic rem_msb_unused;
  assign rem_msb_unused = rem_q[Width] | step_rem[Width];

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    shifted   = {rem_q[Width-1:0], quo_q[Width-1]};
    trial     = shifted - {1'b0, divisor_q};
    borrow    = trial[Width];
    step_rem  = borrow ? shifted : trial;
    step_quo  = {quo_q[Width-2:0], ~borrow};
    last_step = busy_q && (zero_q || (count_q == LastStep));

    busy_d    = busy_q;
    zero_d    = zero_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;

    if (i_start) begin
      busy_d    = 1'b1;
      zero_d    = (i_divisor == '0);
      count_d   = '0;
      rem_d     = '0;
      quo_d     = i_dividend;
      divisor_d = i_divisor;
    end else if (busy_q) begin
      if (!zero_q) begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + step_t'(1);
      end
      if (last_step) busy_d = 1'b0;
    end

    o_done      = last_step;
    o_quotient  = zero_q ? '1 : step_quo;
    o_remainder = zero_q ? quo_q : step_rem[Width-1:0];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      busy_q    <= 1'b0;
      zero_q    <= 1'b0;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
    end else begin
      busy_q    <= busy_d;
      zero_q    <= zero_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
    end
  end

endmodule

// File: rtl/spi_divider.sv
// Spi peripheral that receives a division packet, runs div_core and returns quotient or remainder.
// A one-cycle miso high announces the result, which then follows LSB first.
module spi_divider
  import spi_divider_pkg::*;
#(
  parameter int NssPosition = DIV_NSS_POSITION,
  parameter int Width       = REGISTER_SIZE
) (
  input  logic   i_clock,
  input  logic   i_reset,
  Spi.Peripheral spi,
  output logic   o_busy
);

  localparam int PacketBits = 2 * Width + 1;
  localparam int CountBits  = $clog2(PacketBits);
  typedef logic [CountBits-1:0] count_t;
  localparam count_t LastPacketBit = count_t'(PacketBits - 1);
  localparam count_t LastResultBit = count_t'(Width - 1);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    RECV     = 5'b00010,
    DIVIDE   = 5'b00100,
    ANNOUNCE = 5'b01000,
    SEND     = 5'b10000
  } state_e;

  state_e                state_q, state_d;
  count_t                counter_q, counter_d;
  logic [PacketBits-1:0] packet_q, packet_d;
  logic [Width-1:0]      result_q, result_d;
  logic                  miso_q, miso_d;
  logic                  busy_q, busy_d;

  logic             sel;
  logic             core_start;
  logic [Width-1:0] core_quotient;
  logic [Width-1:0] core_remainder;
  logic             core_done;

  assign sel = ~spi.nss[NssPosition];

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    packet_d   = packet_q;
    result_d   = result_q;
    miso_d     = 1'b0;
    core_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel && spi.mosi) begin
          state_d   = RECV;
          counter_d = '0;
        end
      end
      RECV: begin
        packet_d[counter_q] = spi.mosi;
        counter_d           = counter_q + count_t'(1);
        if (counter_q == LastPacketBit) begin
          state_d    = DIVIDE;
          core_start = 1'b1;
        end
      end
      DIVIDE: begin
        if (core_done) begin
          result_d = packet_q[0] ? core_remainder : core_quotient;
          state_d  = ANNOUNCE;
          miso_d   = 1'b1;
        end
      end
      ANNOUNCE: begin
        state_d   = SEND;
        counter_d = '0;
        miso_d    = result_q[0];
        result_d  = result_q >> 1;
      end
      SEND: begin
        if (counter_q == LastResultBit) begin
          state_d = IDLE;
        end else begin
          counter_d = counter_q + count_t'(1);
          miso_d    = result_q[0];
          result_d  = result_q >> 1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing select aborts everything, including a divide that is about to start.
    if ((state_q != IDLE) && !sel) begin
      state_d    = IDLE;
      miso_d     = 1'b0;
      core_start = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      packet_q  <= '0;
      result_q  <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      packet_q  <= packet_d;
      result_q  <= result_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
    end
  end

  div_core #(
    .Width (Width)
  ) u_div_core (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_start     (core_start),
    .i_dividend  (packet_d[Width:1]),
    .i_divisor   (packet_d[2*Width:Width+1]),
    .o_quotient  (core_quotient),
    .o_remainder (core_remainder),
    .o_done      (core_done)
  );

  assign spi.miso = miso_q;
  assign o_busy   = busy_q;

endmodule
